// File: rtl/scan_tap_pkg.sv
// Shared constants, receive-FSM state type and framing helpers for scan_tap_multi.
// Frame layout: START(0), data LSB first, optional parity, STOP(1).
// Parity modes: none / even (XOR of data and parity = 0) / odd (XOR = 1).
package scan_tap_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   typedef enum logic [1:0] {
      RX_HUNT,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_e;

   // Total bits per frame including start, optional parity and stop.
   function automatic int frame_len(input int data_bits, input int parity);
      return data_bits + 2 + ((parity != PARITY_NONE) ? 1 : 0);
   endfunction

   // Parity bit to transmit after the data bits; data is zero-extended by the caller.
   function automatic logic parity_bit(input logic [8:0] data, input int mode);
      logic p;
      p = ^data;
      if (mode == PARITY_ODD) p = ~p;
      return p;
   endfunction

endpackage

// File: rtl/scan_frame_rx.sv
// Serial NRZ frame receiver: one bit per i_tck, LSB-first data, optional parity.
// o_good / o_bad are combinational during the STOP bit, so the owner acts on the stop edge.
// Controllers should leave at least one idle (1) bit between consecutive frames.
module scan_frame_rx
   import scan_tap_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = PARITY_NONE
) (
   input  logic                 i_tck,
   input  logic                 i_rst,
   input  logic                 i_tdi,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_good,
   output logic                 o_bad
);

   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   rx_state_e            state_q;
   logic [3:0]           cnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_q;
   logic [8:0]           data_ext;
   logic                 par_ok;
   logic                 frame_ok;

   // Receive FSM: hunt for start, shift data, sample parity, then the stop bit.
   always_ff @(posedge i_tck) begin
      if (i_rst) begin
         state_q <= RX_HUNT;
         cnt_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
      end else begin
         case (state_q)
            RX_HUNT: begin
               if (!i_tdi) begin
                  state_q <= RX_DATA;
                  cnt_q   <= '0;
               end
            end
            RX_DATA: begin
               shift_q <= {i_tdi, shift_q[DATA_BITS-1:1]};
               cnt_q   <= cnt_q + 4'd1;
               if (cnt_q == LAST_BIT) begin
                  if (PARITY != PARITY_NONE) state_q <= RX_PARITY;
                  else                       state_q <= RX_STOP;
               end
            end
            RX_PARITY: begin
               par_q   <= i_tdi;
               state_q <= RX_STOP;
            end
            RX_STOP: begin
               state_q <= RX_HUNT;
            end
            default: state_q <= RX_HUNT;
         endcase
      end
   end

   // Frame check: stop bit must be 1 and the parity bit must match the data.
   always_comb begin
      data_ext                 = '0;
      data_ext[DATA_BITS-1:0]  = shift_q;
      par_ok                   = 1'b1;
      if (PARITY != PARITY_NONE) par_ok = (par_q == parity_bit(data_ext, PARITY));
      frame_ok                 = par_ok && i_tdi;
   end

   assign o_data = shift_q;
   assign o_good = (state_q == RX_STOP) && frame_ok;
   assign o_bad  = (state_q == RX_STOP) && !frame_ok;

endmodule

// File: rtl/scan_tap_multi.sv
// Multi-channel scan-chain TAP: address match, per-channel inbound staging and outbound frames.
// Inbound word and o_strobe update on the stop edge of the last channel's frame.
// o_tdo bypasses i_tdi unless this project is active in the data phase.
module scan_tap_multi
   import scan_tap_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int CHANNELS  = 2,
   parameter int PARITY    = PARITY_NONE,
   parameter int ADDR_BITS = 8
) (
   input  logic                          i_tck,
   input  logic                          i_rst,
   input  logic                          i_tms,
   input  logic                          i_tdi,
   input  logic [ADDR_BITS-1:0]          address,
   input  logic [CHANNELS*DATA_BITS-1:0] outbound,
   output logic [CHANNELS*DATA_BITS-1:0] inbound,
   output logic                          o_strobe,
   output logic                          o_frame_err,
   output logic [7:0]                    o_err_count,
   output logic                          o_tck,
   output logic                          o_tms,
   output logic                          o_tdo
);

   localparam int FRAME_LEN = frame_len(DATA_BITS, PARITY);
   localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int WORD_W    = CHANNELS * DATA_BITS;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_good;
   logic                 rx_bad;
   logic                 addr_hit;

   logic                 active_q,  active_d;
   logic [CH_W-1:0]      ch_idx_q,  ch_idx_d;
   logic [WORD_W-1:0]    stage_q,   stage_d;
   logic [WORD_W-1:0]    inbound_q, inbound_d;
   logic                 strobe_q,  strobe_d;
   logic                 ferr_q,    ferr_d;
   logic [7:0]           err_cnt_q, err_cnt_d;
   logic [FRAME_LEN-1:0] tx_q,      tx_d;

   logic [DATA_BITS-1:0] ch_out;
   logic [8:0]           ch_ext;
   logic [FRAME_LEN-1:0] tx_load;

   scan_frame_rx #(
      .DATA_BITS (DATA_BITS),
      .PARITY    (PARITY)
   ) u_rx (
      .i_tck  (i_tck),
      .i_rst  (i_rst),
      .i_tdi  (i_tdi),
      .o_data (rx_data),
      .o_good (rx_good),
      .o_bad  (rx_bad)
   );

   // Data bits above the address field must be zero for a match.
   assign addr_hit = (rx_data[ADDR_BITS-1:0] == address) && ((rx_data >> ADDR_BITS) == '0);

   // Build the outbound frame for the channel currently being received.
   always_comb begin
      ch_out                  = outbound[int'(ch_idx_q)*DATA_BITS +: DATA_BITS];
      ch_ext                  = '0;
      ch_ext[DATA_BITS-1:0]   = ch_out;
      tx_load                 = '1;
      tx_load[0]              = 1'b0;
      tx_load[DATA_BITS:1]    = ch_out;
      if (PARITY != PARITY_NONE) tx_load[DATA_BITS+1] = parity_bit(ch_ext, PARITY);
   end

   // Next-state logic: error counting, address phase clearing, channel staging and tx load.
   always_comb begin
      active_d  = active_q;
      ch_idx_d  = ch_idx_q;
      stage_d   = stage_q;
      inbound_d = inbound_q;
      strobe_d  = 1'b0;
      ferr_d    = 1'b0;
      err_cnt_d = err_cnt_q;
      tx_d      = {1'b1, tx_q[FRAME_LEN-1:1]};

      if (rx_bad) begin
         ferr_d = 1'b1;
         if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end

      if (!i_tms) begin
         // Address phase: idle tx at 1 so o_tdo is high when the mux flips back.
         ch_idx_d  = '0;
         inbound_d = '0;
         tx_d      = '1;
         if (rx_good) active_d = addr_hit;
      end else if (rx_good && active_q) begin
         stage_d[int'(ch_idx_q)*DATA_BITS +: DATA_BITS] = rx_data;
         tx_d = tx_load;
         if (ch_idx_q == LAST_CH) begin
            ch_idx_d  = '0;
            inbound_d = stage_d;
            strobe_d  = 1'b1;
         end else begin
            ch_idx_d = ch_idx_q + 1'b1;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge i_tck) begin
      if (i_rst) begin
         active_q  <= 1'b0;
         ch_idx_q  <= '0;
         stage_q   <= '0;
         inbound_q <= '0;
         strobe_q  <= 1'b0;
         ferr_q    <= 1'b0;
         err_cnt_q <= '0;
         tx_q      <= '1;
      end else begin
         active_q  <= active_d;
         ch_idx_q  <= ch_idx_d;
         stage_q   <= stage_d;
         inbound_q <= inbound_d;
         strobe_q  <= strobe_d;
         ferr_q    <= ferr_d;
         err_cnt_q <= err_cnt_d;
         tx_q      <= tx_d;
      end
   end

   assign inbound     = inbound_q;
   assign o_strobe    = strobe_q;
   assign o_frame_err = ferr_q;
   assign o_err_count = err_cnt_q;
   assign o_tck       = i_tck;
   assign o_tms       = i_tms;
   assign o_tdo       = (i_tms && active_q) ? tx_q[0] : i_tdi;

endmodule

// File: tb/tb_scan_tap_multi.sv
// Bench for scan_tap_multi: default instance plus an even-parity instance.
// Expected inbound words, returned tdo frames and error counts are queued at stimulus time.
// Monitors on the falling edge pop and compare as the DUTs produce output.
module tb_scan_tap_multi;

   logic        tck = 1'b0;
   logic        rst, tms, tdi, tdi_p;
   logic [7:0]  addr;
   logic [15:0] outb, outb_p;
   logic [15:0] inb, inb_p;
   logic        strobe, strobe_p, ferr, ferr_p;
   logic [7:0]  errc, errc_p;
   logic        otck, otck_p, otms, otms_p, tdo, tdo_p;

   int vectors     = 0;
   int miscompares = 0;

   logic [10:0] tdo_q[$];
   logic [15:0] in_q[$], in_p_q[$];
   logic [7:0]  err_q[$], err_p_q[$];

   bit          mon_en = 0, mon_sel = 0, mirror_en = 0, glitch_en = 0;
   bit          d_busy = 0;
   int          d_cnt  = 0;
   logic [10:0] d_frame;

   always #5 tck = ~tck;

   scan_tap_multi dut (
      .i_tck(tck), .i_rst(rst), .i_tms(tms), .i_tdi(tdi), .address(addr),
      .outbound(outb), .inbound(inb), .o_strobe(strobe), .o_frame_err(ferr),
      .o_err_count(errc), .o_tck(otck), .o_tms(otms), .o_tdo(tdo)
   );

   scan_tap_multi #(.DATA_BITS(8), .CHANNELS(2), .PARITY(1), .ADDR_BITS(8)) dut_p (
      .i_tck(tck), .i_rst(rst), .i_tms(tms), .i_tdi(tdi_p), .address(addr),
      .outbound(outb_p), .inbound(inb_p), .o_strobe(strobe_p), .o_frame_err(ferr_p),
      .o_err_count(errc_p), .o_tck(otck_p), .o_tms(otms_p), .o_tdo(tdo_p)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] d, input bit par);
      logic [10:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = d;
      if (par) f[9] = ^d;
      return f;
   endfunction

   task automatic drive_bit(input bit sel, input logic b);
      if (sel) tdi_p = b; else tdi = b;
      @(posedge tck); #1;
   endtask

   task automatic idle(input int n);
      tdi = 1'b1; tdi_p = 1'b1;
      repeat (n) begin @(posedge tck); #1; end
   endtask

   // One frame followed by a single idle bit.
   task automatic send_frame(input bit sel, input logic [7:0] d, input bit par,
                             input bit flip_par, input bit bad_stop);
      logic [10:0] f;
      int n;
      f = make_frame(d, par);
      n = par ? 11 : 10;
      if (flip_par) f[9] = ~f[9];
      if (bad_stop) f[n-1] = 1'b0;
      for (int i = 0; i < n; i++) drive_bit(sel, f[i]);
      drive_bit(sel, 1'b1);
   endtask

   // Inbound strobe scoreboards.
   always @(negedge tck) begin
      if (strobe) begin
         check("strobe_expected", 32'(in_q.size() != 0), 32'd1);
         if (in_q.size() != 0) check("inbound_word", 32'(inb), 32'(in_q.pop_front()));
      end
      if (strobe_p) begin
         check("strobe_p_expected", 32'(in_p_q.size() != 0), 32'd1);
         if (in_p_q.size() != 0) check("inbound_p_word", 32'(inb_p), 32'(in_p_q.pop_front()));
      end
   end

   // Frame error scoreboards: count value expected at each error pulse.
   always @(negedge tck) begin
      if (ferr) begin
         check("ferr_expected", 32'(err_q.size() != 0), 32'd1);
         if (err_q.size() != 0) check("err_count", 32'(errc), 32'(err_q.pop_front()));
      end
      if (ferr_p) begin
         check("ferr_p_expected", 32'(err_p_q.size() != 0), 32'd1);
         if (err_p_q.size() != 0) check("err_count_p", 32'(errc_p), 32'(err_p_q.pop_front()));
      end
   end

   // Returned-frame decoder on o_tdo of the selected instance.
   always @(negedge tck) begin
      logic b;
      logic [10:0] exp_f;
      int flen;
      flen = mon_sel ? 11 : 10;
      b    = mon_sel ? tdo_p : tdo;
      if (!mon_en) begin
         d_busy = 0;
      end else if (!d_busy) begin
         if (b == 1'b0) begin
            d_busy  = 1;
            d_cnt   = 1;
            d_frame = '1;
            d_frame[0] = 1'b0;
         end
      end else begin
         d_frame[d_cnt] = b;
         d_cnt++;
         if (d_cnt == flen) begin
            d_busy = 0;
            check("tdo_frame_expected", 32'(tdo_q.size() != 0), 32'd1);
            if (tdo_q.size() != 0) begin
               exp_f = tdo_q.pop_front();
               check("tdo_frame", 32'(d_frame), 32'(exp_f));
            end
         end
      end
   end

   // Bypass and no-glitch watchers.
   always @(negedge tck) begin
      if (mirror_en) check("bypass_mirror", 32'(tdo), 32'(tdi));
      if (glitch_en) check("no_glitch_low", 32'(tdo), 32'd1);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, %0d vectors applied", vectors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; tms = 1'b0; tdi = 1'b1; tdi_p = 1'b1;
      addr = 8'h2A; outb = 16'hBEEF; outb_p = 16'h0703;
      repeat (2) @(posedge tck);
      #1 rst = 1'b0;

      // Reset state and buffers.
      check("rst_inbound", 32'(inb), 32'd0);
      check("rst_strobe", 32'(strobe), 32'd0);
      check("rst_ferr", 32'(ferr), 32'd0);
      check("rst_errc", 32'(errc), 32'd0);
      check("rst_tdo_bypass", 32'(tdo), 32'(tdi));
      check("o_tms_buf", 32'(otms), 32'(tms));
      check("o_tck_buf", 32'(otck), 32'(tck));
      @(negedge tck); #1;
      check("o_tck_buf_low", 32'(otck), 32'(tck));
      @(posedge tck); #1;

      // Matching address, two data frames, returned channel frames.
      send_frame(0, 8'h2A, 0, 0, 0);
      tms = 1'b1;
      check("o_tms_buf_hi", 32'(otms), 32'd1);
      mon_sel = 0; mon_en = 1;
      tdo_q.push_back(make_frame(8'hEF, 0));
      send_frame(0, 8'h11, 0, 0, 0);
      tdo_q.push_back(make_frame(8'hBE, 0));
      in_q.push_back(16'h2211);
      send_frame(0, 8'h22, 0, 0, 0);
      idle(11);
      mon_en = 0;
      check("t1_inbound_hold", 32'(inb), 32'h2211);

      // Non-matching address: bypass only, no strobe.
      tms = 1'b0;
      send_frame(0, 8'h2B, 0, 0, 0);
      check("t2_inbound_cleared", 32'(inb), 32'd0);
      tms = 1'b1;
      mirror_en = 1;
      send_frame(0, 8'h11, 0, 0, 0);
      send_frame(0, 8'h22, 0, 0, 0);
      idle(2);
      mirror_en = 0;
      check("t2_inbound_zero", 32'(inb), 32'd0);

      // Stop bit forced low: error counter saturates at 255.
      tms = 1'b0;
      for (int i = 0; i < 300; i++) begin
         err_q.push_back((i < 255) ? 8'(i + 1) : 8'hFF);
         send_frame(0, 8'(i), 0, 0, 1);
      end
      idle(2);
      check("sat_count", 32'(errc), 32'd255);

      // Even parity instance: wrong parity rejected, channel index held.
      send_frame(1, 8'h2A, 1, 0, 0);
      tms = 1'b1;
      mon_sel = 1; mon_en = 1;
      err_p_q.push_back(8'd1);
      send_frame(1, 8'h03, 1, 1, 0);
      tdo_q.push_back(make_frame(8'h03, 1));
      send_frame(1, 8'h03, 1, 0, 0);
      tdo_q.push_back(make_frame(8'h07, 1));
      in_p_q.push_back(16'h0403);
      send_frame(1, 8'h04, 1, 0, 0);
      idle(12);
      mon_en = 0;
      check("par_errc", 32'(errc_p), 32'd1);

      // Reset in the middle of the second data frame.
      tms = 1'b0;
      send_frame(0, 8'h2A, 0, 0, 0);
      tms = 1'b1;
      send_frame(0, 8'h11, 0, 0, 0);
      drive_bit(0, 1'b0);
      drive_bit(0, 1'b0);
      drive_bit(0, 1'b1);
      drive_bit(0, 1'b0);
      rst = 1'b1; tdi = 1'b1;
      @(posedge tck); #1;
      rst = 1'b0;
      check("mid_rst_inbound", 32'(inb), 32'd0);
      check("mid_rst_errc", 32'(errc), 32'd0);
      check("mid_rst_strobe", 32'(strobe), 32'd0);
      tdi = 1'b0; #1;
      check("mid_rst_inactive", 32'(tdo), 32'd0);
      tdi = 1'b1; #1;
      check("mid_rst_tdo_idle", 32'(tdo), 32'd1);
      @(posedge tck); #1;
      tms = 1'b0;
      send_frame(0, 8'h2A, 0, 0, 0);
      tms = 1'b1;
      mon_sel = 0; mon_en = 1;
      tdo_q.push_back(make_frame(8'hEF, 0));
      send_frame(0, 8'h55, 0, 0, 0);
      tdo_q.push_back(make_frame(8'hBE, 0));
      in_q.push_back(16'h6655);
      send_frame(0, 8'h66, 0, 0, 0);
      idle(11);
      mon_en = 0;

      // Drop tms after one of two data frames; restart at channel 0.
      outb = 16'h0000;
      tms = 1'b0;
      send_frame(0, 8'h2A, 0, 0, 0);
      tms = 1'b1;
      mon_en = 1;
      tdo_q.push_back(make_frame(8'h00, 0));
      send_frame(0, 8'h5A, 0, 0, 0);
      tdo_q.push_back(make_frame(8'h00, 0));
      in_q.push_back(16'hA55A);
      send_frame(0, 8'hA5, 0, 0, 0);
      send_frame(0, 8'h3C, 0, 0, 0);
      mon_en = 0;
      tms = 1'b0;
      glitch_en = 1;
      idle(2);
      check("drop_inbound_zero", 32'(inb), 32'd0);
      tms = 1'b1;
      idle(4);
      glitch_en = 0;
      mon_en = 1;
      tdo_q.push_back(make_frame(8'h00, 0));
      send_frame(0, 8'h33, 0, 0, 0);
      tdo_q.push_back(make_frame(8'h00, 0));
      in_q.push_back(16'h4433);
      send_frame(0, 8'h44, 0, 0, 0);
      idle(11);
      mon_en = 0;

      check("tdo_q_drained", 32'(tdo_q.size()), 32'd0);
      check("in_q_drained", 32'(in_q.size()), 32'd0);
      check("in_p_q_drained", 32'(in_p_q.size()), 32'd0);
      check("err_q_drained", 32'(err_q.size()), 32'd0);
      check("err_p_q_drained", 32'(err_p_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
